add_unit: RTL and testbench
===========================

Name: add_unit

Overview:
- Registered integer adder: the functional unit behind each HLS "add" call site.
- Takes two WIDTH-bit operands plus a carry-in through a valid/ready handshake.
- Returns sum, carry-out, signed-overflow and zero flags one cycle later through a valid/ready output port.
- Sits between the HLS controller datapath and its consumers; one instance per scheduled add.

Parameters:
- WIDTH, 32, operand and sum width in bits (legal 1..64).
- SIGNED, 1, 1 = overflow flag uses two's-complement rules; 0 = overflow flag mirrors carry-out.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operands presented.
- in_ready  out  1  unit accepts operands this cycle.
- in0  in  WIDTH  operand A.
- in1  in  WIDTH  operand B.
- cin  in  1  carry-in.
- out_valid  out  1  result held in output register.
- out_ready  in  1  consumer takes result this cycle.
- out  out  WIDTH  sum, low WIDTH bits of in0+in1+cin.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  overflow flag.
- zero  out  1  out == 0.

Behaviour:
- Reset (async assert, sync-safe deassert on clk): out_valid=0, out=0, cout=0, ovf=0, zero=1.
- in_ready = !out_valid || out_ready; combinational, no dependence on in_valid.
- Accept: in_valid && in_ready at a rising edge.
  - Computes full = {1'b0,in0} + {1'b0,in1} + cin (WIDTH+1 bits).
  - Registers out=full[WIDTH-1:0], cout=full[WIDTH], zero=(out==0), ovf per SIGNED.
  - Sets out_valid=1.
- Latency exactly 1 cycle from accept to out_valid; throughput 1 result/cycle when out_ready held high.
- Signed overflow: in0[MSB]==in1[MSB] && out[MSB]!=in0[MSB]. Unsigned (SIGNED=0): ovf=cout.
- Drain: out_valid && out_ready && !(in_valid && in_ready) -> out_valid=0 next cycle.
  - Data outputs keep the last value; they are don't-care while out_valid=0.
- Simultaneous drain and accept -> new result replaces old, out_valid stays 1, no bubble.
- Backpressure: out_valid=1 and out_ready=0 -> in_ready=0; output register and flags hold stable.
- Wrap-around: sum truncates modulo 2^WIDTH; the carry is reported only on cout.
- Reset mid-operation: pending result discarded, outputs return to reset values immediately; no in-flight transaction survives.
- No combinational path from in0/in1 to out.

Optional Feature:
- Macro ADD_SATURATE_EN.
- Defined:
  - SIGNED=1: on overflow, out clamps to max positive (0111..1) if in0 is positive, min negative (1000..0) if in0 is negative.
  - SIGNED=0: on carry-out, out clamps to all-ones.
  - cout and ovf still report the unsaturated event; zero is computed on the clamped value.
- Undefined: wrapping sum only; no saturation logic is synthesized.

Test Plan:
1. Reset: assert rst mid-stream with out_valid=1 -> out_valid=0, zero=1, out=0 immediately, in_ready=1 after release.
2. WIDTH=32, in0=5, in1=7, cin=1, out_ready=1 -> next cycle out=13, cout=0, ovf=0, zero=0, out_valid=1.
3. Wrap/carry: in0=0xFFFFFFFF, in1=1, cin=0 -> out=0, cout=1, zero=1; SIGNED=1 gives ovf=0.
4. Signed overflow: in0=0x7FFFFFFF, in1=1 -> out=0x80000000, ovf=1, cout=0.
   - With ADD_SATURATE_EN: out=0x7FFFFFFF, ovf=1.
5. Backpressure: out_ready=0 for 3 cycles after a result -> in_ready=0, out stable for all 3 cycles; release -> result consumed once, next operands accepted that same cycle.
6. Streaming: 8 back-to-back operand pairs with in_valid=1 and out_ready=1 -> 8 consecutive results, one per cycle, in order, each delayed by 1 cycle.

Source files
------------

// File: rtl/add_unit.sv
// add_unit: registered adder with valid/ready handshake and carry/overflow/zero flags.
// Define ADD_SATURATE_EN to clamp the sum on overflow instead of letting it wrap.
module add_unit #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);
  logic [WIDTH:0]   full;
  logic [WIDTH-1:0] out_d, out_q;
  logic             valid_d, valid_q, cout_d, cout_q, ovf_d, ovf_q, zero_q, accept;
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign full     = {1'b0, in0} + {1'b0, in1} + {{WIDTH{1'b0}}, cin};
  assign cout_d   = full[WIDTH];
  assign ovf_d    = SIGNED ? (in0[WIDTH-1] == in1[WIDTH-1]) && (full[WIDTH-1] != in0[WIDTH-1]) : cout_d;
`ifdef ADD_SATURATE_EN
  localparam logic [WIDTH-1:0] MIN_NEG = WIDTH'(1) << (WIDTH - 1);
  // Signed overflow direction follows in0's sign, since both operands share it.
  assign out_d = !ovf_d ? full[WIDTH-1:0] : !SIGNED ? '1 : in0[WIDTH-1] ? MIN_NEG : ~MIN_NEG;
`else
  assign out_d = full[WIDTH-1:0];
`endif
  assign valid_d = accept || (valid_q && !out_ready);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      out_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      valid_q <= valid_d;
      if (accept) begin
        out_q  <= out_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
        zero_q <= (out_d == '0);
      end
    end
  end
  assign out_valid = valid_q;
  assign out       = out_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;
endmodule

// File: tb/tb_add_unit.sv
// tb_add_unit: directed vectors into add_unit, results checked by a queue-based monitor.
module tb_add_unit;
`ifdef ADD_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam int NV = 14;
  localparam logic [31:0] VA [NV] = '{32'h5, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'h0,
    32'h1, 32'hA, 32'h0000FFFF, 32'h12345678, 32'hFFFFFFFE, 32'h40000000, 32'hC0000000, 32'hDEADBEEF};
  localparam logic [31:0] VB [NV] = '{32'h7, 32'h1, 32'h1, 32'h80000000, 32'hFFFFFFFF, 32'h0,
    32'h2, 32'h14, 32'h1, 32'h11111111, 32'h1, 32'h40000000, 32'hC0000000, 32'h21524110};
  localparam logic VC [NV] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam logic [31:0] VO [NV] = '{32'hD, 32'h0, SAT ? 32'h7FFFFFFF : 32'h80000000,
    SAT ? 32'h80000000 : 32'h0, 32'hFFFFFFFF, 32'h0, 32'h3, 32'h1F, 32'h00010000, 32'h23456789, 32'h0,
    SAT ? 32'h7FFFFFFF : 32'h80000000, 32'h80000000, 32'h0};
  // Expected {cout, ovf, zero}
  localparam logic [2:0] VF [NV] = '{3'b000, 3'b101, 3'b010, SAT ? 3'b110 : 3'b111, 3'b100, 3'b001,
    3'b000, 3'b000, 3'b000, 3'b000, 3'b101, 3'b010, 3'b100, 3'b101};

  typedef struct {logic [31:0] o; logic c, v, z; int cyc; bit lat;} exp_t;

  logic clk = 0, rst = 1, in_valid = 0, out_ready = 0, cin = 0;
  logic [31:0] in0 = 0, in1 = 0, out;
  logic in_ready, out_valid, cout, ovf, zero;
  exp_t q[$];
  exp_t mon_e;
  int cyc = 0, n_vec = 0, n_err = 0;
  bit lat_mode = 0;

  add_unit #(.WIDTH(32), .SIGNED(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in0(in0), .in1(in1), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .out(out), .cout(cout), .ovf(ovf), .zero(zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_result: got out=%h expected no result", out);
      end else begin
        mon_e = q.pop_front();
        chk("out", out, mon_e.o);
        chk("cout", 32'(cout), 32'(mon_e.c));
        chk("ovf", 32'(ovf), 32'(mon_e.v));
        chk("zero", 32'(zero), 32'(mon_e.z));
        if (mon_e.lat) chk("latency", 32'(cyc), 32'(mon_e.cyc + 1));
      end
    end
  end

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic c,
                      input logic [31:0] eo, input logic [2:0] ef);
    int n = 0;
    in0 = a;
    in1 = b;
    cin = c;
    in_valid = 1;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL accept_timeout: in_ready=0 required 1");
    end else q.push_back('{eo, ef[2], ef[1], ef[0], cyc, lat_mode});
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out"}, out, 32'd0);
    chk({tag, "_zero"}, 32'(zero), 32'd1);
    chk({tag, "_cout"}, 32'(cout), 32'd0);
    chk({tag, "_ovf"}, 32'(ovf), 32'd0);
  endtask

  initial begin
    @(negedge clk);
    chk_reset("rst0");
    rst = 0;
    @(posedge clk);
    #1;
    out_ready = 1;
    lat_mode = 1;
    for (int i = 0; i < NV; i++) send(VA[i], VB[i], VC[i], VO[i], VF[i]);
    in_valid = 0;
    @(negedge clk);
    @(posedge clk);
    #1;
    lat_mode = 0;
    out_ready = 0;
    send(32'h100, 32'h200, 1'b0, 32'h300, 3'b000);
    in0 = 32'hAAAA0000;
    in1 = 32'h00005555;
    cin = 0;
    in_valid = 1;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_out", out, 32'h300);
    end
    @(posedge clk);
    #1;
    out_ready = 1;
    send(32'hAAAA0000, 32'h00005555, 1'b0, 32'hAAAA5555, 3'b000);
    in_valid = 0;
    @(negedge clk);
    @(posedge clk);
    #1;
    out_ready = 0;
    send(32'h1, 32'h1, 1'b0, 32'h2, 3'b000);
    in_valid = 0;
    @(negedge clk);
    chk("pre_rst_valid", 32'(out_valid), 32'd1);
    rst = 1;
    #1;
    chk_reset("rst1");
    q.delete();
    @(negedge clk);
    rst = 0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1;
    send(32'h3, 32'h4, 1'b0, 32'h7, 3'b000);
    in_valid = 0;
    repeat (10) if (q.size() != 0) @(negedge clk);
    chk("drain", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
